// File: rtl/sfp_slave_responder.sv
// ============================================================================
// Module   : sfp_slave_responder
// Brief    : Slave side of the SFP master/slave frame exchange. Extracts the
//            local slot from the received master stream, presents it to the
//            local side and answers with a stream carrying local data in the
//            same slot, followed by a one-cycle Aurora TX start pulse. Also
//            supervises the link (receive timeout, overrun, bad-ID counts).
// Options  : SFP_SLAVE_ECHO_EN - when defined, non-own slots of the response
//            carry the received stream (daisy-chain pass-through); when not
//            defined, non-own slots are zero.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sfp_slave_responder #(
  parameter int C_AXIS_TDATA_WIDTH = 64,
  parameter int C_NUMBER_OF_SLAVE  = 3,
  parameter int C_NUMBER_OF_FRAME  = 7,
  parameter int C_DATA_FRAME_BIT   = C_AXIS_TDATA_WIDTH * C_NUMBER_OF_FRAME,
  parameter int C_DATA_STREAM_BIT  = C_DATA_FRAME_BIT * C_NUMBER_OF_SLAVE,
  parameter int C_TIMEOUT_CYCLES   = 100000
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_sfp_s_en,
  input  logic [7:0]                   i_slave_id,
  input  logic [C_DATA_STREAM_BIT-1:0] i_stream_data,
  input  logic                         i_sfp_end_flag,
  input  logic [C_DATA_FRAME_BIT-1:0]  i_tx_frame,
  output logic [C_DATA_STREAM_BIT-1:0] o_stream_data,
  output logic                         o_sfp_start_flag,
  output logic [C_DATA_FRAME_BIT-1:0]  o_rx_frame,
  output logic                         o_rx_valid,
  output logic                         o_link_timeout,
  output logic [15:0]                  o_rx_cnt,
  output logic [15:0]                  o_err_cnt,
  output logic                         o_busy,
  output logic [1:0]                   o_state
);

  localparam int c_to_w = $clog2(C_TIMEOUT_CYCLES + 1);
  localparam logic [c_to_w-1:0] c_to_max  = c_to_w'(C_TIMEOUT_CYCLES);
  localparam logic [c_to_w-1:0] c_to_last = c_to_w'(C_TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_LOAD    = 2'd2,
    ST_SEND    = 2'd3
  } state_t;

  state_t                       r_state;
  logic [C_DATA_STREAM_BIT-1:0] r_stream;       // stream being processed
  logic [C_DATA_STREAM_BIT-1:0] r_pend_stream;  // one-deep overrun buffer
  logic                         r_pend;
  logic [C_DATA_FRAME_BIT-1:0]  r_snap;         // local data frozen at capture
  logic [7:0]                   r_id;           // slot index frozen at capture
  logic [C_DATA_FRAME_BIT-1:0]  r_rx_frame;
  logic                         r_rx_valid;
  logic [C_DATA_STREAM_BIT-1:0] r_stream_out;
  logic                         r_start;
  logic [15:0]                  r_rx_cnt;
  logic [15:0]                  r_err_cnt;
  logic [c_to_w-1:0]            r_to_cnt;
  logic                         r_timeout;

  logic                         w_end;
  logic                         w_id_ok;
  logic                         w_drop;
  logic                         w_bad;
  logic [1:0]                   w_err_inc;
  logic [16:0]                  w_err_sum;
  logic [15:0]                  w_err_next;
  logic [C_DATA_FRAME_BIT-1:0]  w_own_slot;
  logic [C_DATA_STREAM_BIT-1:0] w_load;

  // End flags only count while slave mode is enabled.
  assign w_end   = i_sfp_end_flag & i_sfp_s_en;
  assign w_id_ok = ({24'd0, i_slave_id} < 32'(C_NUMBER_OF_SLAVE));
  // A second end flag while one is already pending is lost.
  assign w_drop  = w_end & (r_state != ST_IDLE) & r_pend;
  assign w_bad   = (r_state == ST_CAPTURE) & ~w_id_ok;

  // Error counter step: overrun and bad ID can coincide, so add up to two and saturate.
  always_comb begin
    w_err_inc  = {1'b0, w_drop} + {1'b0, w_bad};
    w_err_sum  = {1'b0, r_err_cnt} + {15'd0, w_err_inc};
    w_err_next = w_err_sum[16] ? 16'hFFFF : w_err_sum[15:0];
  end

  // Select the own slot out of the latched stream.
  always_comb begin
    w_own_slot = '0;
    for (int k = 0; k < C_NUMBER_OF_SLAVE; k++) begin
      if (i_slave_id == 8'(k)) w_own_slot = r_stream[k*C_DATA_FRAME_BIT +: C_DATA_FRAME_BIT];
    end
  end

  // Build the response stream: own slot from the snapshot, others zero or echoed.
  always_comb begin
`ifdef SFP_SLAVE_ECHO_EN
    w_load = r_stream;
`else
    w_load = '0;
`endif
    for (int k = 0; k < C_NUMBER_OF_SLAVE; k++) begin
      if (r_id == 8'(k)) w_load[k*C_DATA_FRAME_BIT +: C_DATA_FRAME_BIT] = r_snap;
    end
  end

  // Exchange FSM with its registered outputs, counters and pending buffer.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state       <= ST_IDLE;
      r_stream      <= '0;
      r_pend_stream <= '0;
      r_pend        <= 1'b0;
      r_snap        <= '0;
      r_id          <= '0;
      r_rx_frame    <= '0;
      r_rx_valid    <= 1'b0;
      r_stream_out  <= '0;
      r_start       <= 1'b0;
      r_rx_cnt      <= '0;
      r_err_cnt     <= '0;
    end else if (!i_sfp_s_en) begin
      // Leaving slave mode abandons any exchange; data and counters hold.
      r_state    <= ST_IDLE;
      r_pend     <= 1'b0;
      r_rx_valid <= 1'b0;
      r_start    <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      r_start    <= 1'b0;
      r_err_cnt  <= w_err_next;
      case (r_state)
        ST_IDLE: begin
          if (r_pend) begin
            // Serve the older, buffered frame first; a fresh flag refills the buffer.
            r_stream <= r_pend_stream;
            r_state  <= ST_CAPTURE;
            r_pend   <= w_end;
            if (w_end) r_pend_stream <= i_stream_data;
          end else if (w_end) begin
            r_stream <= i_stream_data;
            r_state  <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          if (w_id_ok) begin
            r_rx_frame <= w_own_slot;
            r_rx_valid <= 1'b1;
            r_rx_cnt   <= r_rx_cnt + 16'd1;
            r_snap     <= i_tx_frame;
            r_id       <= i_slave_id;
            r_state    <= ST_LOAD;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_LOAD: begin
          r_stream_out <= w_load;
          r_start      <= 1'b1;
          r_state      <= ST_SEND;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
      if ((r_state != ST_IDLE) && w_end && !r_pend) begin
        r_pend        <= 1'b1;
        r_pend_stream <= i_stream_data;
      end
    end
  end

  // Receive watchdog: counts enabled cycles since the last end flag, sticks at the limit.
  always_ff @(posedge i_clk) begin
    if (!i_rst || !i_sfp_s_en) begin
      r_to_cnt  <= '0;
      r_timeout <= 1'b0;
    end else if (i_sfp_end_flag) begin
      r_to_cnt  <= '0;
      r_timeout <= 1'b0;
    end else if (r_to_cnt != c_to_max) begin
      r_to_cnt <= r_to_cnt + 1'b1;
      if (r_to_cnt == c_to_last) r_timeout <= 1'b1;
    end
  end

  assign o_stream_data    = r_stream_out;
  assign o_sfp_start_flag = r_start;
  assign o_rx_frame       = r_rx_frame;
  assign o_rx_valid       = r_rx_valid;
  assign o_link_timeout   = r_timeout;
  assign o_rx_cnt         = r_rx_cnt;
  assign o_err_cnt        = r_err_cnt;
  assign o_busy           = (r_state != ST_IDLE);
  assign o_state          = r_state;

endmodule

`default_nettype wire

// File: doc/sfp_slave_responder.md
Name: sfp_slave_responder

Overview:
- Slave-side counterpart of the SFP master frame exchange.
- Master broadcasts one stream of C_NUMBER_OF_SLAVE slots, each C_NUMBER_OF_FRAME words wide; Aurora RX signals completion with an end-flag pulse.
- This block extracts the local slot (selected by i_slave_id), presents it to the AXI/DSP side, and answers with a TX stream holding local data in the same slot, then pulses the Aurora TX start flag.
- Also supervises the link: receive timeout, overrun and bad-ID counters.

Parameters:
- C_AXIS_TDATA_WIDTH, 64, frame word width.
- C_NUMBER_OF_SLAVE, 3, slots per stream.
- C_NUMBER_OF_FRAME, 7, words per slot.
- C_DATA_FRAME_BIT, C_AXIS_TDATA_WIDTH*C_NUMBER_OF_FRAME, slot width.
- C_DATA_STREAM_BIT, C_DATA_FRAME_BIT*C_NUMBER_OF_SLAVE, stream width.
- C_TIMEOUT_CYCLES, 100000, i_clk cycles without an end flag before timeout.

Ports:
- i_clk  in  1  single clock (AXI clock domain).
- i_rst  in  1  synchronous, active-low reset.
- i_sfp_s_en  in  1  slave mode enable.
- i_slave_id  in  8  own slot index; valid range 0..C_NUMBER_OF_SLAVE-1.
- i_stream_data  in  C_DATA_STREAM_BIT  received master stream; stable when i_sfp_end_flag is high.
- i_sfp_end_flag  in  1  one-cycle pulse, Aurora RX complete.
- i_tx_frame  in  C_DATA_FRAME_BIT  local data to return to master.
- o_stream_data  out  C_DATA_STREAM_BIT  response stream to Aurora TX.
- o_sfp_start_flag  out  1  one-cycle pulse, Aurora TX start.
- o_rx_frame  out  C_DATA_FRAME_BIT  own slot as last received.
- o_rx_valid  out  1  one-cycle pulse when o_rx_frame updates.
- o_link_timeout  out  1  sticky timeout flag.
- o_rx_cnt  out  16  accepted frames, wraps 0xFFFF->0.
- o_err_cnt  out  16  overruns plus bad-ID frames, saturates at 0xFFFF.
- o_busy  out  1  FSM not in IDLE.
- o_state  out  2  FSM state, for debug.

Behaviour:
- Reset (i_rst=0 at a clock edge) sets every output, counter, pending flag and the FSM to 0 / IDLE. Reset mid-exchange aborts it: no start flag is issued afterwards.
- FSM encoding: IDLE=0, CAPTURE=1, LOAD=2, SEND=3.
- Slot k occupies bits [(k+1)*C_DATA_FRAME_BIT-1 : k*C_DATA_FRAME_BIT].
- IDLE -> CAPTURE: on i_sfp_end_flag=1 or pending=1, only when i_sfp_s_en=1. Pending is cleared on this transition.
- CAPTURE:
  - If i_slave_id < C_NUMBER_OF_SLAVE: o_rx_frame <= own slot (from a stream register latched on the end flag); o_rx_valid pulses; o_rx_cnt++; snapshot i_tx_frame; go to LOAD.
  - Otherwise: o_err_cnt++; go to IDLE with no response.
- LOAD: o_stream_data <= own slot = snapshot, all other slots = 0; go to SEND.
- SEND: o_sfp_start_flag=1 for exactly one cycle; go to IDLE.
- Latency: end flag sampled at edge N gives o_rx_valid at N+1, o_stream_data updated at N+2, o_sfp_start_flag high during cycle N+2..N+3. Back-to-back minimum spacing is 4 cycles.
- o_stream_data holds its value between exchanges.
- End flag arriving while not in IDLE:
  - If pending=0: set pending (one-deep) and latch that stream.
  - If pending=1 already: drop the frame, o_err_cnt++.
- Timeout counter: cleared on every end flag. Otherwise increments while i_sfp_s_en=1. On reaching C_TIMEOUT_CYCLES, o_link_timeout <= 1 and the counter holds. The next end flag clears o_link_timeout in the same edge.
- i_sfp_s_en=0:
  - FSM is forced to IDLE next edge; pending, timeout counter and o_link_timeout are cleared.
  - End flags are ignored.
  - o_rx_frame, o_stream_data and all counters hold.
- An end flag coincident with i_sfp_s_en falling is ignored.

Optional Feature:
- SFP_SLAVE_ECHO_EN defined: in LOAD, non-own slots carry the values from the latched received stream (daisy-chain pass-through); the own slot is still replaced by the snapshot.
- SFP_SLAVE_ECHO_EN undefined: non-own slots are zero, as above.

Test Plan:
- id=1, stream slots {0:A, 1:B, 2:C} (each word 64'hA..., 64'hB..., 64'hC...), i_tx_frame=D, end flag at N -> o_rx_valid at N+1 with o_rx_frame=B; start flag at N+2; o_stream_data={0,D,0}; o_rx_cnt=1.
- id=3 with end flag -> no o_rx_valid, no start flag, o_err_cnt=1, o_rx_cnt=0.
- End flags at N, N+1, N+2 -> frame N processed; N+1 pending, processed after SEND (o_rx_valid at N+5); N+2 dropped, o_err_cnt=1.
- C_TIMEOUT_CYCLES=16, enable held, no end flags -> o_link_timeout=1 after 16 cycles; end flag -> cleared next edge; enable=0 -> cleared.
- Reset asserted during LOAD -> no start flag, all outputs 0; afterwards a normal exchange completes with o_rx_cnt=1.
- With SFP_SLAVE_ECHO_EN defined, id=0, slots {A,B,C}, i_tx_frame=D -> o_stream_data={D,B,C}.
